ir_fetch_controller: RTL and testbench

- Moore FSM that sequences the 8-bit-memory to 16-bit instruction register fetch: two byte reads into the IR halves, PC increments, then an execute phase.
- Sits between the control unit and the IR/PC/memory datapath.
- Drives the IR write enable and half select, the memory read strobe and the PC increment.
- Waits for the execute logic to report completion, with a watchdog on execute length.

---
 rtl/ir_fetch_controller.sv | 129 ++++++++++++
 tb/tb_ir_fetch_controller.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_fetch_controller.sv
// Moore FSM that sequences two byte reads into the 16-bit IR, then an execute phase with a watchdog.
// Optional memory wait states are enabled by defining WAIT_STATE_EN.
module ir_fetch_controller #(
    parameter logic HI_FIRST     = 1'b0,
    parameter int   EXEC_TIMEOUT = 15,
    parameter int   TCNT_W       = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Halt,
    input  logic              ExecDone,
    input  logic              MemReady,
    output logic              MemRead,
    output logic              PC_Inc,
    output logic              IR_Write,
    output logic              IR_LH,
    output logic              ExecPhase,
    output logic [TCNT_W-1:0] T,
    output logic              InstrValid,
    output logic              Busy,
    output logic              Fault
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH1 = 3'd1,
        S_FETCH2 = 3'd2,
        S_EXEC   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [TCNT_W-1:0] TIMEOUT_VAL = TCNT_W'(EXEC_TIMEOUT);
    localparam logic [TCNT_W-1:0] T_MAX       = {TCNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [TCNT_W-1:0] t_q, t_d;
    logic              fault_q, fault_d;
    logic              byte_ok;

`ifdef WAIT_STATE_EN
    assign byte_ok = MemReady;
`else
    // Every fetch byte completes in one cycle; MemReady is kept only for port compatibility.
    logic unused_mem_ready;
    assign unused_mem_ready = MemReady;
    assign byte_ok          = 1'b1;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        unique case (state_q)
            S_IDLE:   if (Start) state_d = S_FETCH1;
            S_FETCH1: if (byte_ok) state_d = S_FETCH2;
            S_FETCH2: if (byte_ok) state_d = S_EXEC;
            S_EXEC: begin
                // Completion wins over the watchdog when both land on the same cycle.
                if (ExecDone && Halt) begin
                    state_d = S_HALTED;
                end else if (ExecDone) begin
                    state_d = S_FETCH1;
                end else if (t_q == TIMEOUT_VAL) begin
                    state_d = S_HALTED;
                    fault_d = 1'b1;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // T counts only while EXEC continues; any entry into EXEC starts it from zero.
    always_comb begin
        t_d = '0;
        if (state_q == S_EXEC && state_d == S_EXEC) begin
            t_d = (t_q == T_MAX) ? t_q : t_q + 1'b1;
        end
    end

    always_comb begin
        MemRead    = 1'b0;
        PC_Inc     = 1'b0;
        IR_Write   = 1'b0;
        IR_LH      = 1'b0;
        ExecPhase  = 1'b0;
        InstrValid = 1'b0;
        Busy       = 1'b0;
        unique case (state_q)
            S_FETCH1: begin
                MemRead  = 1'b1;
                IR_Write = byte_ok;
                PC_Inc   = byte_ok;
                IR_LH    = HI_FIRST;
                Busy     = 1'b1;
            end
            S_FETCH2: begin
                MemRead  = 1'b1;
                IR_Write = byte_ok;
                PC_Inc   = byte_ok;
                IR_LH    = ~HI_FIRST;
                Busy     = 1'b1;
            end
            S_EXEC: begin
                ExecPhase  = 1'b1;
                InstrValid = (t_q == '0);
                Busy       = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign T     = t_q;
    assign Fault = fault_q;

endmodule

// File: tb/tb_ir_fetch_controller.sv
// Directed bench for ir_fetch_controller with a small byte-memory / IR / PC datapath model.
module tb_ir_fetch_controller;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       Halt = 1'b0;
    logic       ExecDone = 1'b0;
    logic       MemReady = 1'b1;
    logic       MemRead, PC_Inc, IR_Write, IR_LH, ExecPhase, InstrValid, Busy, Fault;
    logic [7:0] T;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mem [0:7];
    logic [15:0] ir = 16'h0000;
    logic [7:0]  pc;

    ir_fetch_controller #(
        .HI_FIRST(1'b0),
        .EXEC_TIMEOUT(4),
        .TCNT_W(8)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Halt(Halt),
        .ExecDone(ExecDone), .MemReady(MemReady), .MemRead(MemRead),
        .PC_Inc(PC_Inc), .IR_Write(IR_Write), .IR_LH(IR_LH),
        .ExecPhase(ExecPhase), .T(T), .InstrValid(InstrValid),
        .Busy(Busy), .Fault(Fault)
    );

    always #5 Clock = ~Clock;

    initial begin
        mem[0] = 8'h34; mem[1] = 8'h12; mem[2] = 8'h78; mem[3] = 8'h56;
        mem[4] = 8'hBC; mem[5] = 8'h9A; mem[6] = 8'hF0; mem[7] = 8'hDE;
    end

    // Datapath model: IR half write and PC increment driven by the controller strobes.
    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc <= 8'd0;
        end else begin
            if (IR_Write && MemRead) begin
                if (IR_LH) ir[15:8] <= mem[pc[2:0]];
                else       ir[7:0]  <= mem[pc[2:0]];
            end
            if (PC_Inc) pc <= pc + 8'd1;
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Start = 1'b0; Halt = 1'b0; ExecDone = 1'b0; MemReady = 1'b1;
        Reset = 1'b0;
        step();
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        step();
        n_cmp++;
        if ({MemRead, PC_Inc, IR_Write, IR_LH, ExecPhase, InstrValid, Busy, Fault} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 00000000",
                     {MemRead, PC_Inc, IR_Write, IR_LH, ExecPhase, InstrValid, Busy, Fault});
        end
        n_cmp++;
        if (T !== 8'd0) begin n_bad++; $display("FAIL reset_T: got %0d want 0", T); end
        Reset = 1'b1;
        step();
        n_cmp++;
        if (Busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_start_busy: got %b want 0", Busy); end
        $display("reset: outputs idle after reset and without Start");
    endtask

    task automatic test_async_reset();
        do_reset();
        Start = 1'b1;
        step();
        step();
        n_cmp++;
        if ({MemRead, IR_Write, IR_LH} !== 3'b111) begin
            n_bad++; $display("FAIL async_pre_fetch2: got %b want 111", {MemRead, IR_Write, IR_LH});
        end
        #2 Reset = 1'b0;
        #1;
        n_cmp++;
        if ({MemRead, IR_Write, PC_Inc, Busy} !== 4'b0000) begin
            n_bad++; $display("FAIL async_reset_strobes: got %b want 0000", {MemRead, IR_Write, PC_Inc, Busy});
        end
        step();
        Reset = 1'b1;
        step();
        n_cmp++;
        if ({MemRead, IR_Write, PC_Inc, IR_LH} !== 4'b1110) begin
            n_bad++; $display("FAIL async_restart_fetch1: got %b want 1110", {MemRead, IR_Write, PC_Inc, IR_LH});
        end
        $display("async_reset: strobes dropped mid-FETCH2, restart fetched again");
    endtask

    task automatic test_fetch_exec();
        do_reset();
        Start = 1'b1;
        step();
        Start = 1'b0;
        n_cmp++;
        if ({MemRead, IR_Write, PC_Inc, IR_LH, ExecPhase} !== 5'b11100) begin
            n_bad++; $display("FAIL fetch1_outputs: got %b want 11100", {MemRead, IR_Write, PC_Inc, IR_LH, ExecPhase});
        end
        step();
        n_cmp++;
        if ({MemRead, IR_Write, PC_Inc, IR_LH} !== 4'b1111) begin
            n_bad++; $display("FAIL fetch2_outputs: got %b want 1111", {MemRead, IR_Write, PC_Inc, IR_LH});
        end
        step();
        n_cmp++;
        if ({ExecPhase, InstrValid, MemRead, IR_Write, PC_Inc} !== 5'b11000) begin
            n_bad++; $display("FAIL exec0_outputs: got %b want 11000", {ExecPhase, InstrValid, MemRead, IR_Write, PC_Inc});
        end
        n_cmp++;
        if (ir !== 16'h1234) begin n_bad++; $display("FAIL exec0_ir: got %h want 1234", ir); end
        n_cmp++;
        if (pc !== 8'd2) begin n_bad++; $display("FAIL exec0_pc: got %0d want 2", pc); end
        n_cmp++;
        if (T !== 8'd0) begin n_bad++; $display("FAIL exec0_T: got %0d want 0", T); end
        step();
        n_cmp++;
        if ({T, InstrValid} !== {8'd1, 1'b0}) begin
            n_bad++; $display("FAIL exec1_T_iv: got T=%0d iv=%b want T=1 iv=0", T, InstrValid);
        end
        step();
        n_cmp++;
        if (T !== 8'd2) begin n_bad++; $display("FAIL exec2_T: got %0d want 2", T); end
        ExecDone = 1'b1;
        step();
        ExecDone = 1'b0;
        n_cmp++;
        if ({MemRead, IR_Write, IR_LH, ExecPhase, T} !== {4'b1100, 8'd0}) begin
            n_bad++; $display("FAIL done_to_fetch1: got rd=%b wr=%b lh=%b ex=%b T=%0d want 1 1 0 0 0",
                              MemRead, IR_Write, IR_LH, ExecPhase, T);
        end
        $display("fetch_exec: IR=%h PC=%0d then FETCH1", ir, pc);
    endtask

    task automatic test_back_to_back();
        int iv_cycles[$];
        do_reset();
        ExecDone = 1'b1;
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (InstrValid === 1'b1) iv_cycles.push_back(c);
        end
        n_cmp++;
        if (iv_cycles.size() != 3) begin
            n_bad++; $display("FAIL b2b_iv_count: got %0d want 3", iv_cycles.size());
        end else begin
            n_cmp++;
            if (iv_cycles[0] != 2 || iv_cycles[1] != 5 || iv_cycles[2] != 8) begin
                n_bad++; $display("FAIL b2b_iv_spacing: got %0d,%0d,%0d want 2,5,8",
                                  iv_cycles[0], iv_cycles[1], iv_cycles[2]);
            end
        end
        n_cmp++;
        if (pc !== 8'd6) begin n_bad++; $display("FAIL b2b_pc: got %0d want 6", pc); end
        n_cmp++;
        if (ir !== 16'h9ABC) begin n_bad++; $display("FAIL b2b_ir: got %h want 9abc", ir); end
        ExecDone = 1'b0;
        $display("back_to_back: %0d instructions, PC=%0d, IR=%h", iv_cycles.size(), pc, ir);
    endtask

    task automatic test_timeout();
        do_reset();
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        step();
        for (int k = 1; k <= 4; k++) begin
            step();
            n_cmp++;
            if ({ExecPhase, T} !== {1'b1, 8'(k)}) begin
                n_bad++; $display("FAIL timeout_T%0d: got ex=%b T=%0d want ex=1 T=%0d", k, ExecPhase, T, k);
            end
        end
        step();
        n_cmp++;
        if ({Fault, Busy, ExecPhase} !== 3'b100) begin
            n_bad++; $display("FAIL timeout_halted: got fault=%b busy=%b ex=%b want 1 0 0", Fault, Busy, ExecPhase);
        end
        Start = 1'b1;
        step();
        step();
        n_cmp++;
        if ({Fault, Busy, MemRead} !== 3'b100) begin
            n_bad++; $display("FAIL timeout_start_ignored: got fault=%b busy=%b rd=%b want 1 0 0", Fault, Busy, MemRead);
        end
        Start = 1'b0;
        do_reset();
        #1;
        n_cmp++;
        if (Fault !== 1'b0) begin n_bad++; $display("FAIL timeout_reset_clears: got %b want 0", Fault); end
        $display("timeout: watchdog halted with fault, cleared by reset");
    endtask

    task automatic test_halt();
        do_reset();
        Start = 1'b1;
        step();
        Start = 1'b0;
        Halt = 1'b1;
        step();
        n_cmp++;
        if ({MemRead, IR_LH, Busy} !== 3'b111) begin
            n_bad++; $display("FAIL halt_fetch_completes: got %b want 111", {MemRead, IR_LH, Busy});
        end
        step();
        n_cmp++;
        if ({ExecPhase, InstrValid} !== 2'b11) begin
            n_bad++; $display("FAIL halt_exec_entered: got %b want 11", {ExecPhase, InstrValid});
        end
        ExecDone = 1'b1;
        step();
        ExecDone = 1'b0;
        n_cmp++;
        if ({Busy, Fault, PC_Inc, MemRead} !== 4'b0000) begin
            n_bad++; $display("FAIL halt_halted: got %b want 0000", {Busy, Fault, PC_Inc, MemRead});
        end
        step();
        n_cmp++;
        if (pc !== 8'd2) begin n_bad++; $display("FAIL halt_pc: got %0d want 2", pc); end
        Halt = 1'b0;
        $display("halt: executed one instruction then HALTED, PC=%0d", pc);
    endtask

`ifdef WAIT_STATE_EN
    task automatic test_wait_states();
        int rd_cycles = 0;
        int wr_cycles = 0;
        do_reset();
        MemReady = 1'b0;
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin MemReady = 1'b1; #1; end
            if (MemRead === 1'b1) rd_cycles++;
            if (IR_Write === 1'b1 && PC_Inc === 1'b1) wr_cycles++;
            if (c < 2) step();
        end
        n_cmp++;
        if (rd_cycles != 3 || wr_cycles != 1) begin
            n_bad++; $display("FAIL wait_fetch1: got rd=%0d wr=%0d want rd=3 wr=1", rd_cycles, wr_cycles);
        end
        step();
        step();
        n_cmp++;
        if ({InstrValid, ir, pc} !== {1'b1, 16'h1234, 8'd2}) begin
            n_bad++; $display("FAIL wait_result: got iv=%b ir=%h pc=%0d want 1 1234 2", InstrValid, ir, pc);
        end
        $display("wait_states: IR=%h PC=%0d after stalled fetch", ir, pc);
    endtask
`else
    task automatic test_memready_ignored();
        do_reset();
        MemReady = 1'b0;
        Start = 1'b1;
        step();
        Start = 1'b0;
        n_cmp++;
        if ({IR_Write, PC_Inc} !== 2'b11) begin
            n_bad++; $display("FAIL memready_ignored_f1: got %b want 11", {IR_Write, PC_Inc});
        end
        step();
        step();
        n_cmp++;
        if ({InstrValid, ir, pc} !== {1'b1, 16'h1234, 8'd2}) begin
            n_bad++; $display("FAIL memready_ignored_result: got iv=%b ir=%h pc=%0d want 1 1234 2", InstrValid, ir, pc);
        end
        MemReady = 1'b1;
        $display("memready_ignored: fetch took 2 cycles, IR=%h PC=%0d", ir, pc);
    endtask
`endif

    initial begin
        test_reset();
        test_async_reset();
        test_fetch_exec();
        test_back_to_back();
        test_timeout();
        test_halt();
`ifdef WAIT_STATE_EN
        test_wait_states();
`else
        test_memready_ignored();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
